// File: rtl/tt_vc_bus_pkg.sv
// rtl/tt_vc_bus_pkg.sv - shared constants for the vc multiplexed external bus and its responder
package tt_vc_bus_pkg;

    localparam logic [15:0] TMR_BASE_DEFAULT = 16'hFFF0;
    localparam int          TMR_WIN_BYTES    = 16;

    localparam logic [3:0] TMR_OFF_CNT_LO = 4'd0;
    localparam logic [3:0] TMR_OFF_CNT_HI = 4'd1;
    localparam logic [3:0] TMR_OFF_CTRL   = 4'd2;

    localparam int CTRL_PEND_BIT = 0;
    localparam int CTRL_EN_BIT   = 1;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_ADDR_HI = 2'd1,
        PH_ADDR_LO = 2'd2,
        PH_WRITE   = 2'd3
    } bus_phase_e;

    function automatic logic [7:0] tmr_ctrl_byte(input logic pend, input logic en);
        logic [7:0] b;
        b = 8'h00;
        b[CTRL_PEND_BIT] = pend;
        b[CTRL_EN_BIT]   = en;
        return b;
    endfunction

endpackage

// File: rtl/tt_vc_bus_timer.sv
// rtl/tt_vc_bus_timer.sv - down-counting timer with pending/enable control and byte register port
module tt_vc_bus_timer
    import tt_vc_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_in,
    input  logic       wr_en_i,
    input  logic [3:0] wr_off_i,
    input  logic [7:0] wr_data_i,
    input  logic [3:0] rd_off_i,
    output logic [7:0] rd_data_o,
    output logic       irq_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        arm_q, arm_d;
    logic        pend_q, pend_d;
    logic        en_q, en_d;
    logic        irq_q;
    logic        expire;

    always_comb begin
        cnt_d  = cnt_q;
        arm_d  = arm_q;
        pend_d = pend_q;
        en_d   = en_q;
        expire = 1'b0;
        if (arm_q && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                expire = 1'b1;
                arm_d  = 1'b0;
            end
        end
        // Register writes override the decrement; a cnt-hi write (re)arms.
        if (wr_en_i) begin
            case (wr_off_i)
                TMR_OFF_CNT_LO: cnt_d[7:0] = wr_data_i;
                TMR_OFF_CNT_HI: begin
                    cnt_d[15:8] = wr_data_i;
                    arm_d       = 1'b1;
                end
                TMR_OFF_CTRL: begin
                    en_d = wr_data_i[CTRL_EN_BIT];
                    if (wr_data_i[CTRL_PEND_BIT]) begin
                        pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            cnt_q  <= 16'd0;
            arm_q  <= 1'b0;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            arm_q  <= arm_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            irq_q  <= pend_q & en_q;
        end
    end

    always_comb begin
        rd_data_o = 8'h00;
        case (rd_off_i)
            TMR_OFF_CNT_LO: rd_data_o = cnt_q[7:0];
            TMR_OFF_CNT_HI: rd_data_o = cnt_q[15:8];
            TMR_OFF_CTRL:   rd_data_o = tmr_ctrl_byte(pend_q, en_q);
            default:        rd_data_o = 8'h00;
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/tt_vc_bus_responder.sv
// rtl/tt_vc_bus_responder.sv - memory-side responder: address latch, decode, byte RAM and timer
module tt_vc_bus_responder
    import tt_vc_bus_pkg::*;
#(
    parameter int          MEM_AW   = 10,
    parameter logic [15:0] TMR_BASE = TMR_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [7:0] bus_ad,
    input  logic       bus_latch_hi,
    input  logic       bus_latch_lo,
    input  logic       bus_write,
    input  logic       bus_ind,
    output logic [7:0] rd_data,
    output logic       irq,
    output logic       proto_err
);

    logic [7:0]  a_hi_q, a_hi_d;
    logic [6:0]  a_lo_q, a_lo_d;
    logic        proto_err_q, proto_err_d;
    logic [6:0]  lo_sel;
    logic [15:0] ea;
    logic        in_tmr;
    logic        wr_ok;
    logic [7:0]  tmr_rd;
    logic [7:0]  mem_q [2**MEM_AW];

    // The low address is bypassed so the master can sample the even byte during latch_lo.
    assign lo_sel = bus_latch_lo ? bus_ad[7:1] : a_lo_q;
    assign ea     = {a_hi_q, lo_sel, bus_ind};
    assign in_tmr = (ea[15:4] == TMR_BASE[15:4]);
    assign wr_ok  = bus_write & ~bus_latch_hi & ~bus_latch_lo & ~reset_in;

    always_comb begin
        a_hi_d      = a_hi_q;
        a_lo_d      = a_lo_q;
        proto_err_d = proto_err_q
                    | (bus_latch_hi & bus_latch_lo)
                    | (bus_write & (bus_latch_hi | bus_latch_lo));
        if (bus_latch_hi) begin
            a_hi_d = bus_ad;
        end else if (bus_latch_lo) begin
            a_lo_d = bus_ad[7:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            a_hi_q      <= 8'h00;
            a_lo_q      <= 7'h00;
            proto_err_q <= 1'b0;
        end else begin
            a_hi_q      <= a_hi_d;
            a_lo_q      <= a_lo_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !in_tmr) begin
            mem_q[ea[MEM_AW-1:0]] <= bus_ad;
        end
    end

    tt_vc_bus_timer u_timer (
        .clk       (clk),
        .reset_in  (reset_in),
        .wr_en_i   (wr_ok & in_tmr),
        .wr_off_i  (ea[3:0]),
        .wr_data_i (bus_ad),
        .rd_off_i  (ea[3:0]),
        .rd_data_o (tmr_rd),
        .irq_o     (irq)
    );

    assign rd_data   = in_tmr ? tmr_rd : mem_q[ea[MEM_AW-1:0]];
    assign proto_err = proto_err_q;

endmodule
